alu_issue_stage: RTL and testbench

Two-stage pipelined issue/retire stage that drives the 64-bit ALU from the instruction side. It accepts a raw RV64I OP / OP-IMM instruction plus register operands over a valid/ready handshake. It decodes the 4-bit ALU opcode and operand B, registers them into the ALU, and captures result and flags into an output register with its own valid/ready handshake. It sits between register read and writeback in the execute path.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_64_bit.sv | 51 +++++
 rtl/alu_op_decode.sv | 70 +++++++
 rtl/alu_issue_stage.sv | 149 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the RV64I OP / OP-IMM issue path and the 64-bit ALU.
package alu_pkg;

    // ALU opcode is {sub_sra, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct7 for register ops, funct6 for 64-bit immediate shifts
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [5:0] FUNCT6_BASE = 6'b000000;
    localparam logic [5:0] FUNCT6_ALT  = 6'b010000;

    // funct3 values that carry special decode rules
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/alu_64_bit.sv
// Purely combinational 64-bit ALU with carry, signed-overflow and zero flags.
// Carry is the adder carry-out (for SUB: 1 means no borrow); other ops clear it.
module alu_64_bit
    import alu_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  opcode,
    output logic [63:0] result,
    output logic        carry_flag,
    output logic        overflow_flag,
    output logic        zero_flag
);

    logic [64:0] sum_w;
    logic [64:0] diff_w;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} + {1'b0, ~b} + 65'd1;

    // Select the operation result and the arithmetic flags
    always_comb begin
        result        = '0;
        carry_flag    = 1'b0;
        overflow_flag = 1'b0;
        case (opcode)
            ALU_ADD: begin
                result        = sum_w[63:0];
                carry_flag    = sum_w[64];
                overflow_flag = (a[63] == b[63]) && (sum_w[63] != a[63]);
            end
            ALU_SUB: begin
                result        = diff_w[63:0];
                carry_flag    = diff_w[64];
                overflow_flag = (a[63] != b[63]) && (diff_w[63] != a[63]);
            end
            ALU_SLL:  result = a << b[5:0];
            ALU_SLT:  result = {63'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {63'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[5:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[5:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero_flag = (result == 64'd0);

endmodule

// File: rtl/alu_op_decode.sv
// Combinational decode of an RV64I OP / OP-IMM word into ALU opcode, operand B
// and an illegal flag. Illegal encodings yield opcode ADD with b = 0.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [63:0] rs2_data,
    output logic [3:0]  opcode,
    output logic [63:0] b,
    output logic        illegal
);

    logic [6:0]  major;
    logic [6:0]  funct7;
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic        is_shift;
    logic        sub_sra;
    logic [63:0] imm_sext;
    logic [63:0] shamt_imm;
    logic [63:0] shamt_reg;
    logic        unused_fields;

    assign major     = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign funct6    = instr[31:26];
    assign is_shift  = (funct3 == F3_SLL) || (funct3 == F3_SR);
    assign imm_sext  = {{52{instr[31]}}, instr[31:20]};
    assign shamt_imm = {58'b0, instr[25:20]};
    assign shamt_reg = {58'b0, rs2_data[5:0]};
    // rd and rs1 fields are consumed by register read, not here
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // Decode legality, operand B and the sub/sra selector by major opcode
    always_comb begin
        sub_sra = 1'b0;
        b       = '0;
        illegal = 1'b1;
        opcode  = ALU_ADD;
        case (major)
            OPC_OP: begin
                sub_sra = instr[30];
                b       = is_shift ? shamt_reg : rs2_data;
                illegal = !((funct7 == FUNCT7_BASE) ||
                            ((funct7 == FUNCT7_ALT) &&
                             ((funct3 == F3_ADD) || (funct3 == F3_SR))));
            end
            OPC_OP_IMM: begin
                // Only right shifts use bit 30, so ADDI never subtracts
                sub_sra = (funct3 == F3_SR) ? instr[30] : 1'b0;
                b       = is_shift ? shamt_imm : imm_sext;
                if (funct3 == F3_SLL)
                    illegal = (funct6 != FUNCT6_BASE);
                else if (funct3 == F3_SR)
                    illegal = !((funct6 == FUNCT6_BASE) || (funct6 == FUNCT6_ALT));
                else
                    illegal = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            opcode = ALU_ADD;
            b      = '0;
        end else begin
            opcode = {sub_sra, funct3};
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire stage: stage 1 holds decoded operands feeding the ALU,
// stage 2 captures the ALU result and flags behind a valid/ready output.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_overflow,
    output logic              out_zero,
    output logic              out_illegal,
    output logic [31:0]       op_count
);

    logic [3:0]        dec_opcode;
    logic [DATA_W-1:0] dec_b;
    logic              dec_illegal;

    logic              s1_valid_q, s1_valid_d;
    logic [3:0]        s1_op_q, s1_op_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic              s1_illegal_q, s1_illegal_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_carry_q, out_carry_d;
    logic              out_overflow_q, out_overflow_d;
    logic              out_zero_q, out_zero_d;
    logic              out_illegal_q, out_illegal_d;
    logic [31:0]       op_count_q, op_count_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_overflow, alu_zero;
    logic              s1_adv, accept, retire;

    alu_op_decode u_decode (
        .instr    (instr),
        .rs2_data (rs2_data),
        .opcode   (dec_opcode),
        .b        (dec_b),
        .illegal  (dec_illegal)
    );

    alu_64_bit u_alu (
        .a             (s1_a_q),
        .b             (s1_b_q),
        .opcode        (s1_op_q),
        .result        (alu_result),
        .carry_flag    (alu_carry),
        .overflow_flag (alu_overflow),
        .zero_flag     (alu_zero)
    );

    // Handshake: stage 1 drains into stage 2 whenever stage 2 is empty or retiring
    assign s1_adv   = s1_valid_q & (!out_valid_q | out_ready);
    assign in_ready = !s1_valid_q | s1_adv;
    assign accept   = in_valid & in_ready;
    assign retire   = out_valid_q & out_ready;

    // Next-state for both pipeline stages and the retire counter
    always_comb begin
        // stage 1: operand register
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_illegal_d = s1_illegal_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = dec_opcode;
            s1_a_d       = dec_illegal ? '0 : rs1_data;
            s1_b_d       = dec_b;
            s1_illegal_d = dec_illegal;
        end else if (s1_adv) begin
            s1_valid_d   = 1'b0;
        end

        // stage 2: result register
        out_valid_d    = out_valid_q;
        out_result_d   = out_result_q;
        out_carry_d    = out_carry_q;
        out_overflow_d = out_overflow_q;
        out_zero_d     = out_zero_q;
        out_illegal_d  = out_illegal_q;
        if (s1_adv) begin
            out_valid_d    = 1'b1;
            out_result_d   = alu_result;
            out_carry_d    = alu_carry;
            out_overflow_d = alu_overflow;
            out_zero_d     = alu_zero;
            out_illegal_d  = s1_illegal_q;
        end else if (out_ready) begin
            out_valid_d    = 1'b0;
        end

        op_count_d = op_count_q + {31'b0, retire};
    end

    // State registers; reset empties both stages at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_op_q        <= ALU_ADD;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_illegal_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_carry_q    <= 1'b0;
            out_overflow_q <= 1'b0;
            out_zero_q     <= 1'b0;
            out_illegal_q  <= 1'b0;
            op_count_q     <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_op_q        <= s1_op_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_illegal_q   <= s1_illegal_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_carry_q    <= out_carry_d;
            out_overflow_q <= out_overflow_d;
            out_zero_q     <= out_zero_d;
            out_illegal_q  <= out_illegal_d;
            op_count_q     <= op_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = out_overflow_q;
    assign out_zero     = out_zero_q;
    assign out_illegal  = out_illegal_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic        out_illegal;
    logic [31:0] op_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_count    = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_illegal  (out_illegal),
        .op_count     (op_count)
    );

    // R-type: rd=x1, rs1=x2, rs2=x3
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
    endfunction

    // I-type: rd=x1, rs1=x2
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd2, f3, 5'd1, 7'b0010011};
    endfunction

    // Issue one op with out_ready high, wait (bounded) for its result, let it retire
    task automatic issue_and_wait(input logic [31:0] ins, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res,
                                  output logic c, output logic v, output logic z,
                                  output logic ill, output int lat);
        @(negedge clk);
        instr = ins; rs1_data = a; rs2_data = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = out_result; c = out_carry; v = out_overflow; z = out_zero; ill = out_illegal;
        if (out_valid) exp_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_result !== 64'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", out_result); end
        tests_run++;
        if ({out_carry, out_overflow, out_zero, out_illegal} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags got %b want 0000", {out_carry, out_overflow, out_zero, out_illegal});
        end
        tests_run++;
        if (op_count !== 32'd0) begin tests_failed++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add;
        logic [63:0] r; logic c, v, z, il; int lat;
        issue_and_wait(enc_r(7'b0000000, 3'b000), 64'd5, 64'd10, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'd15) begin tests_failed++; $display("FAIL add_result got %h want 15", r); end
        tests_run++;
        if (z !== 1'b0 || il !== 1'b0) begin tests_failed++; $display("FAIL add_zero_illegal got %b%b want 00", z, il); end
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL add_latency got %0d want 2", lat); end
        tests_run++;
        if (op_count !== 32'd1) begin tests_failed++; $display("FAIL add_op_count got %0d want 1", op_count); end
    endtask

    task automatic test_sub_addi;
        logic [63:0] r; logic c, v, z, il; int lat;
        issue_and_wait(enc_r(7'b0100000, 3'b000), 64'd5, 64'd5, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'd0 || z !== 1'b1) begin tests_failed++; $display("FAIL sub_result got %h z=%b want 0 z=1", r, z); end
        issue_and_wait(enc_i(12'hFFF, 3'b000), 64'd0, 64'd123, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || z !== 1'b0) begin
            tests_failed++; $display("FAIL addi_neg1 got %h z=%b want ffffffffffffffff z=0", r, z);
        end
    endtask

    task automatic test_shift_imm;
        logic [63:0] r; logic c, v, z, il; int lat;
        issue_and_wait(enc_i(12'h43F, 3'b101), 64'h8000_0000_0000_0000, 64'd0, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || il !== 1'b0) begin
            tests_failed++; $display("FAIL srai63 got %h ill=%b want ffffffffffffffff ill=0", r, il);
        end
        issue_and_wait(enc_i(12'h401, 3'b001), 64'h1234, 64'd0, r, c, v, z, il, lat);
        tests_run++;
        if (il !== 1'b1 || r !== 64'd0) begin tests_failed++; $display("FAIL slli_alt_illegal got ill=%b r=%h want ill=1 r=0", il, r); end
        tests_run++;
        if ({c, v, z} !== 3'b001) begin tests_failed++; $display("FAIL illegal_flags got %b want 001", {c, v, z}); end
    endtask

    task automatic test_compare;
        logic [63:0] r; logic c, v, z, il; int lat;
        issue_and_wait(enc_i(12'hFFF, 3'b011), 64'd1, 64'd0, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'd1) begin tests_failed++; $display("FAIL sltiu got %h want 1", r); end
        issue_and_wait(enc_r(7'b0000000, 3'b010), -64'sd5, 64'd3, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'd1) begin tests_failed++; $display("FAIL slt got %h want 1", r); end
        tests_run++;
        if (op_count !== 32'(exp_count)) begin tests_failed++; $display("FAIL op_count_singles got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_back_to_back;
        int acc = 0, ret = 0, cyc = 0, stall_rdy = 0, held_bad = 0, stall_empty = 0;
        logic [63:0] held = '0;
        while (ret < 8 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (acc < 8);
            instr     = enc_r(7'b0000000, 3'b000);
            rs1_data  = 64'(acc * 100);
            rs2_data  = 64'(acc);
            #1;
            if (!out_ready) begin
                if (in_ready) stall_rdy++;
                if (!out_valid) stall_empty++;
                if (cyc > 4 && out_result !== held) held_bad++;
                held = out_result;
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_result !== 64'(ret * 101)) begin
                    tests_failed++; $display("FAIL b2b_order idx %0d got %0d want %0d", ret, out_result, ret * 101);
                end
                ret++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            cyc++;
        end
        #1 in_valid = 1'b0;
        exp_count += ret;
        tests_run++;
        if (ret !== 8 || acc !== 8) begin tests_failed++; $display("FAIL b2b_counts retired %0d accepted %0d want 8 8", ret, acc); end
        tests_run++;
        if (stall_rdy !== 0 || stall_empty !== 0) begin
            tests_failed++; $display("FAIL b2b_stall in_ready_high %0d out_empty %0d want 0 0", stall_rdy, stall_empty);
        end
        tests_run++;
        if (held_bad !== 0) begin tests_failed++; $display("FAIL b2b_hold changed %0d want 0", held_bad); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_dup out_valid got %b want 0", out_valid); end
        tests_run++;
        if (op_count !== 32'(exp_count)) begin tests_failed++; $display("FAIL b2b_op_count got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_reset_midflight;
        logic [63:0] r; logic c, v, z, il; int lat;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        instr = enc_r(7'b0000000, 3'b000); rs1_data = 64'd1; rs2_data = 64'd2;
        @(posedge clk);
        #1 rs1_data = 64'd3; rs2_data = 64'd4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_before_rst out_valid %b in_ready %b want 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || op_count !== 32'd0) begin
            tests_failed++; $display("FAIL async_rst out_valid %b op_count %0d want 0 0", out_valid, op_count);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL async_rst_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        issue_and_wait(enc_r(7'b0000000, 3'b000), 64'd7, 64'd8, r, c, v, z, il, lat);
        tests_run++;
        if (r !== 64'd15 || lat !== 2) begin tests_failed++; $display("FAIL post_rst_op got %h lat %0d want 15 lat 2", r, lat); end
        tests_run++;
        if (op_count !== 32'd1) begin tests_failed++; $display("FAIL post_rst_count got %0d want 1", op_count); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_addi;
        test_shift_imm;
        test_compare;
        test_back_to_back;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
